// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
// The rd field is sized for the widest supported register index and zero-extended on entry.
package hazard_pkg;

  localparam int SB_RD_W = 8;
  localparam int SEL_RF  = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wer;
    logic               is_load;
  } sb_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter used for the hazard unit performance statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and load-use interlock unit for the in-order pipeline.
// A shift-register scoreboard tracks in-flight writes; entry 0 is the stage right after decode.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rs1,
  input  logic [REG_AW-1:0]         id_rs2,
  input  logic                      id_uses_rs2,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_wer,
  input  logic                      id_is_load,
  input  logic [XLEN-1:0]           rf_rv1,
  input  logic [XLEN-1:0]           rf_rv2,
  input  logic [DEPTH*XLEN-1:0]     stage_data,
  input  logic                      flush,
  output logic [XLEN-1:0]           fwd_rv1,
  output logic [XLEN-1:0]           fwd_rv2,
  output logic [sel_w(DEPTH)-1:0]   fwd_sel1,
  output logic [sel_w(DEPTH)-1:0]   fwd_sel2,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt,
  output logic [CNT_W-1:0]          fwd_cnt
);

  localparam int SW = sel_w(DEPTH);

  sb_entry_t         r_sb [DEPTH];
  sb_entry_t         w_new;
  logic [XLEN-1:0]   w_stage [DEPTH];
  logic [REG_AW-1:0] w_src [2];
  logic              w_src_en [2];
  logic [XLEN-1:0]   w_rf [2];
  logic              w_stall;
  logic              w_accept;
  logic              w_any_fwd;

  genvar k, s;

  for (k = 0; k < DEPTH; k++) begin : g_stage
    assign w_stage[k] = stage_data[k*XLEN +: XLEN];
  end

  assign w_src[0]    = id_rs1;
  assign w_src[1]    = id_rs2;
  assign w_src_en[0] = 1'b1;
  assign w_src_en[1] = id_uses_rs2;
  assign w_rf[0]     = rf_rv1;
  assign w_rf[1]     = rf_rv2;

  // Per source: scan oldest to youngest so the lowest-index match overwrites any older one.
  for (s = 0; s < 2; s++) begin : g_src
    logic            w_found;
    int              w_idx;
    logic            w_ready;
    logic [SW-1:0]   w_sel;
    logic            w_hazard;
    logic [XLEN-1:0] w_data;

    always_comb begin
      w_found = 1'b0;
      w_idx   = 0;
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (r_sb[j].valid && r_sb[j].wer && w_src_en[s] &&
            (w_src[s] != '0) && (r_sb[j].rd == SB_RD_W'(w_src[s]))) begin
          w_found = 1'b1;
          w_idx   = j;
        end
      end
    end

    assign w_ready = !r_sb[w_idx].is_load || (w_idx >= LOAD_LAT);

    always_comb begin
      w_sel    = SW'(SEL_RF);
      w_hazard = 1'b0;
      if (w_found) begin
        if ((FWD_EN != 0) && w_ready) begin
          w_sel = SW'(w_idx + 1);
        end else begin
          w_hazard = 1'b1;
        end
      end
    end

    assign w_data = (w_sel == SW'(SEL_RF)) ? w_rf[s] : w_stage[w_idx];
  end

  assign fwd_sel1 = g_src[0].w_sel;
  assign fwd_sel2 = g_src[1].w_sel;
  assign fwd_rv1  = g_src[0].w_data;
  assign fwd_rv2  = g_src[1].w_data;

  // A flush kills the decode instruction, so it never needs to wait.
  assign w_stall   = id_valid && (g_src[0].w_hazard || g_src[1].w_hazard) && !flush;
  assign w_accept  = id_valid && !w_stall && !flush;
  assign w_any_fwd = w_accept && ((fwd_sel1 != SW'(SEL_RF)) || (fwd_sel2 != SW'(SEL_RF)));
  assign stall     = w_stall;

  always_comb begin
    w_new = '0;
    if (w_accept) begin
      w_new.valid   = 1'b1;
      w_new.rd      = SB_RD_W'(id_rd);
      w_new.wer     = id_wer;
      w_new.is_load = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_sb[j] <= '0;
      end
    end else begin
      r_sb[0] <= w_new;
      for (int j = 1; j < DEPTH; j++) begin
        r_sb[j] <= r_sb[j-1];
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fwd_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_any_fwd),
    .count (fwd_cnt)
  );

endmodule
